gshare_bht: RTL and testbench

//  Parametrised successor to the 2-bit bimodal branch history table. Predicts branch direction and target
//  in the fetch stage: index = PC bits XOR speculative global history (gshare). Counter width is configurable.

---
 rtl/gshare_bht_pkg.sv | 26 ++
 rtl/gshare_bht_sat_ctr.sv | 20 ++
 rtl/gshare_bht.sv | 106 ++++++++++
 tb/tb_gshare_bht.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gshare_bht_pkg.sv
// Shared branch-predictor types and helpers: FSM encoding, gshare index hash and
// counter constants, reused by the gshare table and a future chooser table.
package gshare_bht_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } fsm_e;

    // PC slice XOR history, masked to idx_bits; history above idx_bits falls off in the mask.
    function automatic logic [63:0] bp_idx(
        input logic [63:0] pc,
        input logic [63:0] hist,
        input int unsigned pc_lsb,
        input int unsigned idx_bits
    );
        logic [63:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return ((pc >> pc_lsb) ^ hist) & mask;
    endfunction

    function automatic int unsigned weak_taken(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 32'd1);
    endfunction

endpackage

// File: rtl/gshare_bht_sat_ctr.sv
// Next value of one saturating direction counter: count toward taken or not-taken,
// clamping at all-ones and zero.
module gshare_bht_sat_ctr #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] i_ctr,
    input  logic                i_taken,
    output logic [CTR_BITS-1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != '1) o_ctr = i_ctr + CTR_BITS'(1);
        end else begin
            if (i_ctr != '0) o_ctr = i_ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_bht.sv
// Gshare branch history table: fetch-stage direction/target prediction with speculative
// global history, execute-stage training and mispredict history repair.
module gshare_bht
    import gshare_bht_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned HIST_LEN    = 6,
    parameter int unsigned PC_LSB      = 0,
    localparam int unsigned IDX_BITS   = $clog2(NUM_ENTRIES),
    localparam int unsigned GW         = (HIST_LEN == 0) ? 1 : HIST_LEN
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pred_valid,
    input  logic [ADDR_WIDTH-1:0] i_pred_pc,
    input  logic [ADDR_WIDTH-1:0] i_skip_off,
    input  logic [ADDR_WIDTH-1:0] i_take_off,
    output logic                  o_pred_ready,
    output logic                  o_pred_take,
    output logic [ADDR_WIDTH-1:0] o_pred_target,
    output logic [GW-1:0]         o_pred_ghr,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic [GW-1:0]         i_upd_ghr,
    input  logic                  i_upd_taken,
    input  logic                  i_upd_mispred
);

    localparam logic [CTR_BITS-1:0] WEAK_T = CTR_BITS'(weak_taken(CTR_BITS));

    fsm_e                r_state, w_state_nxt;
    logic [IDX_BITS-1:0] r_ptr;
    logic [GW-1:0]       r_ghr, w_ghr_nxt;
    logic [CTR_BITS-1:0] r_tbl [NUM_ENTRIES];

    logic [IDX_BITS-1:0] w_pidx, w_uidx;
    logic [CTR_BITS-1:0] w_pctr, w_uctr, w_unext;
    logic [63:0]         w_phist, w_uhist;
    logic                w_ready, w_take, w_accept, w_train, w_repair;

    assign w_ready  = (r_state == ST_READY);
    assign w_phist  = (HIST_LEN == 0) ? 64'd0 : 64'(r_ghr);
    assign w_uhist  = (HIST_LEN == 0) ? 64'd0 : 64'(i_upd_ghr);
    assign w_pidx   = IDX_BITS'(bp_idx(64'(i_pred_pc), w_phist, PC_LSB, IDX_BITS));
    assign w_uidx   = IDX_BITS'(bp_idx(64'(i_upd_pc), w_uhist, PC_LSB, IDX_BITS));
    assign w_pctr   = r_tbl[w_pidx];
    assign w_uctr   = r_tbl[w_uidx];
    assign w_take   = w_ready & w_pctr[CTR_BITS-1];
    assign w_accept = i_pred_valid & w_ready;
    assign w_train  = i_upd_valid & w_ready;
    assign w_repair = w_train & i_upd_mispred;

    assign o_pred_ready  = w_ready;
    assign o_pred_take   = w_take;
    assign o_pred_target = i_pred_pc + (w_take ? i_take_off : i_skip_off);
    assign o_pred_ghr    = r_ghr;

    gshare_bht_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .i_ctr   (w_uctr),
        .i_taken (i_upd_taken),
        .o_ctr   (w_unext)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  if (r_ptr == IDX_BITS'(NUM_ENTRIES - 1)) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    // Repair wins over a same-cycle speculative shift; shifting in a GW-wide vector keeps HIST_LEN=1 legal.
    always_comb begin
        w_ghr_nxt = r_ghr;
        if (HIST_LEN == 0)  w_ghr_nxt = '0;
        else if (w_repair)  w_ghr_nxt = (i_upd_ghr << 1) | GW'(i_upd_taken);
        else if (w_accept)  w_ghr_nxt = (r_ghr << 1) | GW'(w_take);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_ghr <= '0;
        end else begin
            if (r_state == ST_INIT) r_ptr <= r_ptr + IDX_BITS'(1);
            r_ghr <= w_ghr_nxt;
        end
    end

    // No reset on the array: the INIT sweep is the only initialisation path.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == ST_INIT) r_tbl[r_ptr]  <= WEAK_T;
            else if (w_train)       r_tbl[w_uidx] <= w_unext;
        end
    end

endmodule

// File: tb/tb_gshare_bht.sv
// Scoreboard bench for gshare_bht: a 64-entry/4-bit-history instance and a 16-entry
// pure-bimodal instance, checked against a small behavioural model.
module tb_gshare_bht;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: 64 entries, HIST_LEN=4
    logic        a_rst, a_pv, a_ready, a_take, a_uv, a_utk, a_umis;
    logic [31:0] a_pc, a_skip, a_toff, a_target, a_upc;
    logic [3:0]  a_pghr, a_ughr;
    // instance B: 16 entries, HIST_LEN=0
    logic        b_rst, b_pv, b_ready, b_take, b_uv, b_utk, b_umis;
    logic [31:0] b_pc, b_skip, b_toff, b_target, b_upc;
    logic [0:0]  b_pghr, b_ughr;

    gshare_bht #(.NUM_ENTRIES(64), .ADDR_WIDTH(32), .CTR_BITS(2), .HIST_LEN(4), .PC_LSB(0)) u_dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_pred_valid(a_pv), .i_pred_pc(a_pc),
        .i_skip_off(a_skip), .i_take_off(a_toff), .o_pred_ready(a_ready),
        .o_pred_take(a_take), .o_pred_target(a_target), .o_pred_ghr(a_pghr),
        .i_upd_valid(a_uv), .i_upd_pc(a_upc), .i_upd_ghr(a_ughr),
        .i_upd_taken(a_utk), .i_upd_mispred(a_umis)
    );

    gshare_bht #(.NUM_ENTRIES(16), .ADDR_WIDTH(32), .CTR_BITS(2), .HIST_LEN(0), .PC_LSB(0)) u_dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_pred_valid(b_pv), .i_pred_pc(b_pc),
        .i_skip_off(b_skip), .i_take_off(b_toff), .o_pred_ready(b_ready),
        .o_pred_take(b_take), .o_pred_target(b_target), .o_pred_ghr(b_pghr),
        .i_upd_valid(b_uv), .i_upd_pc(b_upc), .i_upd_ghr(b_ughr),
        .i_upd_taken(b_utk), .i_upd_mispred(b_umis)
    );

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned mta[64];
    int unsigned mtb[16];
    logic [3:0]  mghr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int unsigned sel);
        case (sel)
            0: return 32'(a_ready);
            1: return 32'(a_take);
            2: return a_target;
            3: return 32'(a_pghr);
            4: return 32'(b_ready);
            5: return 32'(b_take);
            6: return b_target;
            7: return 32'(b_pghr);
            default: return '0;
        endcase
    endfunction

    function automatic int unsigned sat(input int unsigned c, input logic t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic push_exp(input string tag, input int unsigned sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_cycle(input logic pv, input logic [31:0] pc, input logic uv,
                           input logic [31:0] upc, input logic [3:0] ughr,
                           input logic utk, input logic umis, input string tag);
        int unsigned pi, ui;
        logic        tk;
        a_pv = pv; a_pc = pc; a_uv = uv; a_upc = upc; a_ughr = ughr; a_utk = utk; a_umis = umis;
        pi = 32'(pc[5:0] ^ {2'b00, mghr});
        tk = (mta[pi] >= 2);
        push_exp({tag, "_rdy"}, 0, 32'd1);
        push_exp({tag, "_take"}, 1, 32'(tk));
        push_exp({tag, "_tgt"}, 2, pc + (tk ? 32'd8 : 32'd4));
        push_exp({tag, "_ghr"}, 3, 32'(mghr));
        ui = 32'(upc[5:0] ^ {2'b00, ughr});
        if (uv) mta[ui] = sat(mta[ui], utk);
        if (uv && umis) mghr = {ughr[2:0], utk};
        else if (pv)    mghr = {mghr[2:0], tk};
        step();
    endtask

    task automatic b_cycle(input logic pv, input logic [31:0] pc, input logic uv,
                           input logic [31:0] upc, input logic utk, input string tag);
        int unsigned pi, ui;
        logic        tk;
        b_pv = pv; b_pc = pc; b_uv = uv; b_upc = upc; b_utk = utk; b_umis = uv;
        pi = 32'(pc[3:0]);
        tk = (mtb[pi] >= 2);
        push_exp({tag, "_rdy"}, 4, 32'd1);
        push_exp({tag, "_take"}, 5, 32'(tk));
        push_exp({tag, "_tgt"}, 6, pc + (tk ? 32'h40 : 32'h2));
        push_exp({tag, "_ghr"}, 7, 32'd0);
        ui = 32'(upc[3:0]);
        if (uv) mtb[ui] = sat(mtb[ui], utk);
        step();
    endtask

    initial begin
        a_pv = 0; a_pc = '0; a_uv = 0; a_upc = '0; a_ughr = '0; a_utk = 0; a_umis = 0;
        b_pv = 0; b_pc = '0; b_uv = 0; b_upc = '0; b_ughr = '0; b_utk = 0; b_umis = 0;
        a_skip = 32'd4; a_toff = 32'd8; b_skip = 32'h2; b_toff = 32'h40;
        for (int i = 0; i < 64; i++) mta[i] = 2;
        for (int i = 0; i < 16; i++) mtb[i] = 2;
        mghr = '0;

        a_rst = 1; b_rst = 1;
        @(posedge clk); #1;
        a_rst = 0; b_rst = 0;

        // sweep with predicts and repairs presented; none may be accepted
        a_pv = 1; a_pc = 32'h100; a_uv = 1; a_umis = 1; a_ughr = 4'hF; a_utk = 1;
        for (int i = 0; i < 20; i++) begin
            push_exp("init_rdy", 0, 32'd0);
            push_exp("init_take", 1, 32'd0);
            push_exp("init_tgt", 2, 32'h104);
            push_exp("init_ghr", 3, 32'd0);
            push_exp("b_init_rdy", 4, (i >= 16) ? 32'd1 : 32'd0);
            step();
        end
        a_rst = 1;
        push_exp("midrst_rdy", 0, 32'd0);
        step();
        a_rst = 0;
        for (int i = 0; i < 64; i++) begin
            push_exp("resweep_rdy", 0, 32'd0);
            push_exp("resweep_ghr", 3, 32'd0);
            step();
        end
        a_pv = 0; a_uv = 0; a_umis = 0;

        for (int j = 0; j < 64; j++) a_cycle(0, 32'h100 + 32'(j), 0, '0, '0, 0, 0, "weak_t");

        for (int j = 0; j < 4; j++) a_cycle(1, 32'h100, 0, '0, '0, 0, 0, "ghr_shift");
        a_cycle(0, 32'h100, 0, '0, '0, 0, 0, "ghr_full");

        a_cycle(0, 32'h100, 1, 32'h200, 4'b0101, 1, 1, "set1011");
        a_cycle(1, 32'h100, 1, 32'h200, 4'b0010, 1, 1, "repair");
        a_cycle(0, 32'h100, 1, 32'h210, 4'b0101, 0, 0, "train_only");
        a_cycle(0, 32'h100, 0, '0, '0, 0, 0, "ghr_kept");

        a_cycle(0, 32'h3, 1, 32'h20, 4'b0001, 1, 1, "alias_set");
        a_cycle(0, 32'h3, 0, '0, '0, 0, 0, "alias_pre");
        a_cycle(0, 32'h3, 1, 32'h0, 4'b0000, 0, 0, "alias_train");
        a_cycle(0, 32'h3, 0, '0, '0, 0, 0, "alias_post");
        a_cycle(0, 32'h0, 1, 32'h30, 4'b0000, 0, 1, "to_ghr0");
        a_cycle(0, 32'h0, 0, '0, '0, 0, 0, "alias_other");
        a_cycle(0, 32'h0, 1, 32'h0, 4'b0000, 1, 0, "same_cyc");
        a_cycle(0, 32'h0, 0, '0, '0, 0, 0, "after_bump");

        for (int j = 0; j < 3; j++) b_cycle(1, 32'h5, 1, 32'h5, 1, "sat_up");
        b_cycle(1, 32'h5, 0, '0, 0, "sat_hi");
        for (int j = 0; j < 2; j++) b_cycle(1, 32'h5, 1, 32'h5, 0, "down");
        b_cycle(1, 32'h5, 0, '0, 0, "weak_nt");
        for (int j = 0; j < 3; j++) b_cycle(1, 32'h5, 1, 32'h5, 0, "sat_dn");
        b_cycle(1, 32'h5, 1, 32'h5, 1, "from0");
        b_cycle(1, 32'h5, 1, 32'h5, 1, "from1");
        b_cycle(1, 32'h5, 0, '0, 0, "back_wt");
        b_cycle(1, 32'h6, 0, '0, 0, "b_untouched");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
